// File: rtl/axi_br_allocator.sv
// R-channel allocator for one target port: round-robin grant over master ports, held for a whole burst.
// Define AXI_BR_ALLOC_OUT_REG_EN to add a 2-entry output skid slice after the payload mux.
module axi_br_allocator #(
   parameter int N_INIT_PORT = 8,
   parameter int N_TARG_PORT = 8,
   parameter int AXI_ID_IN   = 16,
   parameter int AXI_ID_OUT  = AXI_ID_IN + $clog2(N_TARG_PORT),
   parameter int AXI_DATA_W  = 64,
   parameter int AXI_USER_W  = 6
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [N_INIT_PORT-1:0]             rvalid_i,
   output logic [N_INIT_PORT-1:0]             rready_o,
   input  logic [N_INIT_PORT*AXI_ID_OUT-1:0]  rid_i,
   input  logic [N_INIT_PORT*AXI_DATA_W-1:0]  rdata_i,
   input  logic [N_INIT_PORT*2-1:0]           rresp_i,
   input  logic [N_INIT_PORT-1:0]             rlast_i,
   input  logic [N_INIT_PORT*AXI_USER_W-1:0]  ruser_i,
   output logic                               rvalid_o,
   input  logic                               rready_i,
   output logic [AXI_ID_IN-1:0]               rid_o,
   output logic [AXI_DATA_W-1:0]              rdata_o,
   output logic [1:0]                         rresp_o,
   output logic                               rlast_o,
   output logic [AXI_USER_W-1:0]              ruser_o
);
   localparam int IDX_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;
   localparam int PW    = AXI_ID_IN + AXI_DATA_W + 2 + 1 + AXI_USER_W;

   typedef enum logic {ST_ARB, ST_LOCK} state_t;

   state_t                 r_state, w_state_next;
   logic [IDX_W-1:0]       r_rr_ptr, r_lock_idx;
   logic [IDX_W-1:0]       w_arb_idx, w_grant_idx, w_sel_idx, w_ptr_inc;
   logic                   w_arb_found, w_grant_vld;
   logic [N_INIT_PORT-1:0] w_req;
   logic [PW-1:0]          w_slice [N_INIT_PORT];
   logic [PW-1:0]          w_mux;
   logic                   w_mux_valid, w_mux_last;
   logic                   w_in_ready, w_in_hs, w_in_hs_last;
   logic                   w_unused_route;

   // Routing bits in the upper part of each rid are dropped on the way out.
   assign w_unused_route = ^rid_i;

   genvar gi;
   generate
      for (gi = 0; gi < N_INIT_PORT; gi++) begin : g_slice
         assign w_slice[gi] = {rid_i[gi*AXI_ID_OUT +: AXI_ID_IN],
                               rdata_i[gi*AXI_DATA_W +: AXI_DATA_W],
                               rresp_i[gi*2 +: 2],
                               rlast_i[gi],
                               ruser_i[gi*AXI_USER_W +: AXI_USER_W]};
         assign rready_o[gi] = rst_n & w_grant_vld & w_in_ready & (w_grant_idx == IDX_W'(gi));
      end
   endgenerate

   // Requests are masked while in reset so nothing is granted or acknowledged.
   assign w_req = rvalid_i & {N_INIT_PORT{rst_n}};

   always_comb begin
      w_arb_found = 1'b0;
      w_arb_idx   = '0;
      for (int i = 0; i < N_INIT_PORT; i++) begin
         if (!w_arb_found && w_req[(int'(r_rr_ptr) + i) % N_INIT_PORT]) begin
            w_arb_found = 1'b1;
            w_arb_idx   = IDX_W'((int'(r_rr_ptr) + i) % N_INIT_PORT);
         end
      end
   end

   assign w_grant_vld  = (r_state == ST_LOCK) | w_arb_found;
   assign w_grant_idx  = (r_state == ST_LOCK) ? r_lock_idx : w_arb_idx;
   assign w_sel_idx    = w_grant_vld ? w_grant_idx : r_rr_ptr;
   assign w_mux        = w_slice[w_sel_idx];
   assign w_mux_last   = w_mux[AXI_USER_W];
   assign w_mux_valid  = w_grant_vld & w_req[w_grant_idx];
   assign w_in_hs      = w_mux_valid & w_in_ready;
   assign w_in_hs_last = w_in_hs & w_mux_last;
   assign w_ptr_inc    = (w_grant_idx == IDX_W'(N_INIT_PORT - 1)) ? '0 : w_grant_idx + IDX_W'(1);

   // A pending, unaccepted beat also locks, keeping the winner stable while valid is high.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_ARB:  if (w_arb_found && !(w_in_ready && w_mux_last)) w_state_next = ST_LOCK;
         ST_LOCK: if (w_in_hs_last) w_state_next = ST_ARB;
         default: w_state_next = ST_ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_ARB;
         r_rr_ptr   <= '0;
         r_lock_idx <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_ARB && w_state_next == ST_LOCK) r_lock_idx <= w_arb_idx;
         if (w_in_hs_last) r_rr_ptr <= w_ptr_inc;
      end
   end

`ifdef AXI_BR_ALLOC_OUT_REG_EN
   logic [PW-1:0] r_buf [2];
   logic          r_wr_ptr, r_rd_ptr;
   logic [1:0]    r_cnt;
   logic          w_pop;

   // Two entries let a beat be accepted every cycle while rready_o never depends on rready_i.
   assign w_in_ready = (r_cnt != 2'd2);
   assign w_pop      = (r_cnt != 2'd0) & rready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf[0] <= '0;
         r_buf[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_in_hs) begin
            r_buf[r_wr_ptr] <= w_mux;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_cnt <= r_cnt + {1'b0, w_in_hs} - {1'b0, w_pop};
      end
   end

   assign rvalid_o = (r_cnt != 2'd0);
   assign {rid_o, rdata_o, rresp_o, rlast_o, ruser_o} = r_buf[r_rd_ptr];
`else
   assign w_in_ready = rready_i;
   assign rvalid_o   = w_mux_valid;
   assign {rid_o, rdata_o, rresp_o, rlast_o, ruser_o} = w_mux;
`endif

endmodule

// File: tb/tb_axi_br_allocator.sv
// Directed bench for axi_br_allocator (default build): reset, round-robin, burst lock,
// back-pressure, pointer wrap, stalled locked master and reset mid-burst.
module tb_axi_br_allocator;
   localparam int N   = 8;
   localparam int IDI = 16;
   localparam int IDO = 19;
   localparam int DW  = 64;
   localparam int UW  = 6;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    rvalid_i, rready_o, rlast_i;
   logic [N*IDO-1:0] rid_i;
   logic [N*DW-1:0] rdata_i;
   logic [N*2-1:0]  rresp_i;
   logic [N*UW-1:0] ruser_i;
   logic            rvalid_o, rready_i, rlast_o;
   logic [IDI-1:0]  rid_o;
   logic [DW-1:0]   rdata_o;
   logic [1:0]      rresp_o;
   logic [UW-1:0]   ruser_o;
   logic [31:0]     tb_beat [N];

   int checks   = 0;
   int failures = 0;

   axi_br_allocator dut (
      .clk(clk), .rst_n(rst_n),
      .rvalid_i(rvalid_i), .rready_o(rready_o), .rid_i(rid_i), .rdata_i(rdata_i),
      .rresp_i(rresp_i), .rlast_i(rlast_i), .ruser_i(ruser_i),
      .rvalid_o(rvalid_o), .rready_i(rready_i), .rid_o(rid_o), .rdata_o(rdata_o),
      .rresp_o(rresp_o), .rlast_o(rlast_o), .ruser_o(ruser_o)
   );

   always #5 clk = ~clk;

   // Master k: rid = {routing 3'b111, 16'hB000+k}, rdata = {32'hDA7A0000+k, beat}.
   always_comb begin
      rid_i   = '0;
      rdata_i = '0;
      rresp_i = '0;
      ruser_i = '0;
      for (int k = 0; k < N; k++) begin
         rid_i[k*IDO +: IDO] = {3'b111, 16'hB000 + 16'(k)};
         rdata_i[k*DW +: DW] = {32'hDA7A_0000 + 32'(k), tb_beat[k]};
         rresp_i[k*2 +: 2]   = 2'(k);
         ruser_i[k*UW +: UW] = 6'(k + 8);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic grant(input string tag, input int m, input logic [31:0] beat, input logic last);
      logic [7:0] one;
      one = 8'h01;
      chk({tag, ".rvalid"}, 64'(rvalid_o), 64'd1);
      chk({tag, ".rid"},    64'(rid_o), 64'(16'hB000 + 16'(m)));
      chk({tag, ".rdata"},  rdata_o, {32'hDA7A_0000 + 32'(m), beat});
      chk({tag, ".rlast"},  64'(rlast_o), 64'(last));
      chk({tag, ".rready"}, 64'(rready_o), rready_i ? 64'(one << m) : 64'd0);
      $display("txn %s: master=%0d beat=%0d last=%0b", tag, m, beat, last);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   initial begin
      for (int k = 0; k < N; k++) tb_beat[k] = 32'd0;
      rst_n    = 1'b0;
      rvalid_i = 8'hFF;
      rlast_i  = 8'hFF;
      rready_i = 1'b1;
      #12;
      chk("reset.rvalid", 64'(rvalid_o), 64'd0);
      chk("reset.rready", 64'(rready_o), 64'd0);
      tick();
      rst_n    = 1'b1;
      rvalid_i = 8'h00;
      settle();
      chk("idle.rvalid", 64'(rvalid_o), 64'd0);
      chk("idle.rready", 64'(rready_o), 64'd0);
      chk("idle.rid_ptr0", 64'(rid_o), 64'h0000_B000);
      tick();

      // Round-robin between masters 0 and 2 with single-beat bursts
      rvalid_i = 8'h05;
      rlast_i  = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         settle();
         grant($sformatf("rr%0d", i), (i % 2 == 0) ? 0 : 2, 32'd0, 1'b1);
         tick();
      end

      // Master 3 4-beat burst, master 1 requesting throughout (pointer is at 3)
      rvalid_i = 8'h0A;
      rlast_i  = 8'h02;
      for (int b = 0; b < 4; b++) begin
         tb_beat[3] = 32'(b);
         rlast_i[3] = (b == 3);
         settle();
         grant($sformatf("lock_b%0d", b), 3, 32'(b), b == 3);
         tick();
      end
      rvalid_i = 8'h02;
      settle();
      grant("lock_next", 1, 32'd0, 1'b1);
      tick();

      // Back-pressure on master 5; master 2 (ahead of 5 in pointer order) joins
      rvalid_i = 8'h20;
      rlast_i  = 8'hFF;
      rready_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) rvalid_i = 8'h24;
         settle();
         grant($sformatf("bp%0d", c), 5, 32'd0, 1'b1);
         tick();
      end
      rready_i = 1'b1;
      settle();
      grant("bp_hs", 5, 32'd0, 1'b1);
      tick();
      rvalid_i = 8'h04;
      settle();
      grant("bp_next", 2, 32'd0, 1'b1);
      tick();

      // Move pointer to 7, then wrap to 0
      rvalid_i = 8'h40;
      settle();
      grant("wrap_pre", 6, 32'd0, 1'b1);
      tick();
      rvalid_i = 8'h81;
      settle();
      grant("wrap7", 7, 32'd0, 1'b1);
      tick();
      settle();
      grant("wrap0", 0, 32'd0, 1'b1);
      tick();

      // Master 4 stalls mid-burst while master 6 waits (pointer is at 1)
      rvalid_i = 8'h50;
      rlast_i  = 8'h40;
      for (int b = 0; b < 2; b++) begin
         tb_beat[4] = 32'(b);
         settle();
         grant($sformatf("stall_b%0d", b), 4, 32'(b), 1'b0);
         tick();
      end
      rvalid_i = 8'h40;
      for (int c = 0; c < 2; c++) begin
         settle();
         chk($sformatf("stall_gap%0d.rvalid", c), 64'(rvalid_o), 64'd0);
         chk($sformatf("stall_gap%0d.rready", c), 64'(rready_o), 64'h10);
         chk($sformatf("stall_gap%0d.rid", c), 64'(rid_o), 64'h0000_B004);
         $display("txn stall_gap%0d: held on master 4", c);
         tick();
      end
      rvalid_i = 8'h50;
      for (int b = 2; b < 4; b++) begin
         tb_beat[4] = 32'(b);
         rlast_i[4] = (b == 3);
         settle();
         grant($sformatf("stall_b%0d", b), 4, 32'(b), b == 3);
         tick();
      end
      rvalid_i = 8'h40;
      settle();
      grant("stall_next", 6, 32'd0, 1'b1);
      tick();
      rvalid_i = 8'h00;
      settle();
      chk("idle2.rvalid", 64'(rvalid_o), 64'd0);
      chk("idle2.rid_ptr7", 64'(rid_o), 64'h0000_B007);
      tick();

      // Reset mid-burst from master 1 clears lock and pointer
      rvalid_i = 8'h02;
      rlast_i  = 8'h00;
      settle();
      grant("rst_burst", 1, 32'd0, 1'b0);
      tick();
      rst_n = 1'b0;
      settle();
      chk("rst_mid.rvalid", 64'(rvalid_o), 64'd0);
      chk("rst_mid.rready", 64'(rready_o), 64'd0);
      tick();
      rst_n    = 1'b1;
      rvalid_i = 8'h03;
      rlast_i  = 8'hFF;
      settle();
      grant("post_rst", 0, 32'd0, 1'b1);
      tick();
      rvalid_i = 8'h00;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
